// File: rtl/ultrasonic_ranger_multi.sv
// rtl/ultrasonic_ranger_multi.sv - round-robin multi-channel HC-SR04 ranging engine
module ultrasonic_ranger_multi #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int NUM_CH     = 2,
    parameter int DIST_W     = 9,
    parameter int TRIG_US    = 10,
    parameter int TIMEOUT_US = 25000,
    parameter int CYCLE_US   = 60000,
    parameter int US_PER_CM  = 58,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     continuous,
    input  logic [NUM_CH-1:0]        echo,
    output logic [NUM_CH-1:0]        trigger,
    output logic [NUM_CH*DIST_W-1:0] distance,
    output logic [NUM_CH-1:0]        dist_valid,
    output logic [NUM_CH-1:0]        err,
    output logic                     done,
    output logic [CH_W-1:0]          done_ch,
    output logic                     busy
);

    localparam int TICKS  = CLK_HZ / 1_000_000;
    localparam int PRE_W  = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam int US_MAX = (TIMEOUT_US > TRIG_US) ? TIMEOUT_US : TRIG_US;
    localparam int US_W   = $clog2(US_MAX + 1);
    localparam int SLOT_W = $clog2(CYCLE_US + 1);
    localparam int SUB_W  = $clog2(US_PER_CM + 1);

    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICKS - 1);
    localparam logic [US_W-1:0]   TRIG_LAST = US_W'(TRIG_US - 1);
    localparam logic [US_W-1:0]   TO_LAST   = US_W'(TIMEOUT_US - 1);
    localparam logic [US_W-1:0]   US_SAT    = US_W'(US_MAX);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(CYCLE_US - 1);
    localparam logic [SLOT_W-1:0] SLOT_SAT  = SLOT_W'(CYCLE_US);
    localparam logic [SUB_W-1:0]  SUB_LAST  = SUB_W'(US_PER_CM - 1);
    localparam logic [DIST_W-1:0] CM_SAT    = '1;
    localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(NUM_CH - 1);

    typedef enum logic [2:0] {IDLE, TRIG, WAIT_ECHO, MEASURE, HOLDOFF} state_t;

    state_t             state_q, state_d;
    logic [CH_W-1:0]    ch_q, ch_d;
    logic [NUM_CH-1:0]  sync1_q, sync2_q, sync3_q;
    logic [PRE_W-1:0]   pre_q;
    logic [US_W-1:0]    us_q;
    logic [PRE_W-1:0]   slot_pre_q;
    logic [SLOT_W-1:0]  slot_us_q;
    logic [SUB_W-1:0]   sub_q;
    logic [DIST_W-1:0]  cm_q;
    logic               tick, slot_tick, echo_rise, echo_fall;
    logic               res_ok, res_to, done_d;

    assign tick      = (pre_q == PRE_LAST);
    assign slot_tick = (slot_pre_q == PRE_LAST);
    assign echo_rise = sync2_q[ch_q] & ~sync3_q[ch_q];
    assign echo_fall = ~sync2_q[ch_q] & sync3_q[ch_q];
    assign busy      = (state_q != IDLE);

    // two-flop synchroniser plus one history flop for edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            sync3_q <= '0;
        end else begin
            sync1_q <= echo;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    // state and channel registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            ch_q    <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
        end
    end

    // next-state, channel advance and result strobes
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        res_ok  = 1'b0;
        res_to  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start || continuous) begin
                    state_d = TRIG;
                    ch_d    = '0;
                end
            end
            TRIG: begin
                if (tick && us_q == TRIG_LAST) state_d = WAIT_ECHO;
            end
            WAIT_ECHO: begin
                if (echo_rise) begin
                    state_d = MEASURE;
                end else if (tick && us_q == TO_LAST) begin
                    res_to  = 1'b1;
                    state_d = HOLDOFF;
                end
            end
            MEASURE: begin
                if (echo_fall) begin
                    res_ok  = 1'b1;
                    state_d = HOLDOFF;
                end else if (tick && us_q == TO_LAST) begin
                    res_to  = 1'b1;
                    state_d = HOLDOFF;
                end
            end
            HOLDOFF: begin
                if (slot_tick && slot_us_q >= SLOT_LAST) begin
                    done_d = 1'b1;
                    if (ch_q != CH_LAST) begin
                        ch_d    = ch_q + CH_W'(1);
                        state_d = TRIG;
                    end else if (continuous) begin
                        ch_d    = '0;
                        state_d = TRIG;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // per-state us prescaler and counters; all restart on state entry, slot timer on TRIG entry
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_q      <= '0;
            us_q       <= '0;
            sub_q      <= '0;
            cm_q       <= '0;
            slot_pre_q <= '0;
            slot_us_q  <= '0;
        end else begin
            if (state_d != state_q) begin
                pre_q <= '0;
                us_q  <= '0;
                sub_q <= '0;
                cm_q  <= '0;
            end else begin
                pre_q <= tick ? '0 : pre_q + PRE_W'(1);
                if (tick && us_q != US_SAT) us_q <= us_q + US_W'(1);
                if (tick && state_q == MEASURE) begin
                    if (sub_q == SUB_LAST) begin
                        sub_q <= '0;
                        if (cm_q != CM_SAT) cm_q <= cm_q + DIST_W'(1);
                    end else begin
                        sub_q <= sub_q + SUB_W'(1);
                    end
                end
            end
            if (state_d == TRIG && state_q != TRIG) begin
                slot_pre_q <= '0;
                slot_us_q  <= '0;
            end else begin
                slot_pre_q <= slot_tick ? '0 : slot_pre_q + PRE_W'(1);
                if (slot_tick && slot_us_q != SLOT_SAT) slot_us_q <= slot_us_q + SLOT_W'(1);
            end
        end
    end

    // registered trigger, done pulse and per-channel result registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            trigger    <= '0;
            distance   <= '0;
            dist_valid <= '0;
            err        <= '0;
            done       <= 1'b0;
            done_ch    <= '0;
        end else begin
            trigger <= '0;
            if (state_d == TRIG) trigger[ch_d] <= 1'b1;
            done <= done_d;
            if (done_d) done_ch <= ch_q;
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_q == CH_W'(i)) begin
                    if (res_ok) begin
                        distance[i*DIST_W +: DIST_W] <= cm_q;
                        dist_valid[i]                <= 1'b1;
                        err[i]                       <= 1'b0;
                    end else if (res_to) begin
                        distance[i*DIST_W +: DIST_W] <= CM_SAT;
                        dist_valid[i]                <= 1'b0;
                        err[i]                       <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ultrasonic_ranger_multi.sv
// tb/tb_ultrasonic_ranger_multi.sv - table-driven bench for ultrasonic_ranger_multi
`timescale 1ns/1ps
module tb_ultrasonic_ranger_multi;

    localparam int PER      = 500;
    localparam int US       = 1000;
    localparam int SLOT_CYC = 6000;
    localparam int TRIG_CYC = 20;
    localparam int TO_CYC   = 4000;

    logic        clk = 1'b0;
    logic        reset, start, continuous;
    logic        echo0_drv = 1'b0, echo1_drv = 1'b0;
    logic [1:0]  echo;
    logic [1:0]  trigger;
    logic [17:0] distance;
    logic [1:0]  dist_valid, err;
    logic        done, done_ch, busy;

    logic        start_s, cont_s, echo_s = 1'b0;
    logic [0:0]  trigger_s, dist_valid_s, err_s, done_ch_s;
    logic [3:0]  distance_s;
    logic        done_s, busy_s;

    assign echo = {echo1_drv, echo0_drv};

    always #(PER/2) clk = ~clk;

    ultrasonic_ranger_multi #(
        .CLK_HZ(2_000_000), .NUM_CH(2), .DIST_W(9), .TRIG_US(10),
        .TIMEOUT_US(2000), .CYCLE_US(3000), .US_PER_CM(58)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .continuous(continuous),
        .echo(echo), .trigger(trigger), .distance(distance),
        .dist_valid(dist_valid), .err(err), .done(done),
        .done_ch(done_ch), .busy(busy)
    );

    ultrasonic_ranger_multi #(
        .CLK_HZ(2_000_000), .NUM_CH(1), .DIST_W(4), .TRIG_US(10),
        .TIMEOUT_US(25000), .CYCLE_US(3000), .US_PER_CM(58)
    ) dut_sat (
        .clk(clk), .reset(reset), .start(start_s), .continuous(cont_s),
        .echo(echo_s), .trigger(trigger_s), .distance(distance_s),
        .dist_valid(dist_valid_s), .err(err_s), .done(done_s),
        .done_ch(done_ch_s), .busy(busy_s)
    );

    typedef struct {
        int pre0, dly0, wid0;
        int pre1, dly1, wid1;
        int exp_d0, exp_v0, exp_e0;
        int exp_d1, exp_v1, exp_e1;
    } vec_t;

    int   cfg_pre[2], cfg_dly[2], cfg_wid[2];
    int   n_chk = 0, n_fail = 0, overlap = 0;
    time  t_rise[2], t_fall[2], t_err1;
    int   rise_q[$];
    time  rise_t[$];
    bit   ok, ok_s;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_done(input string name, output bit seen);
        seen = 1'b0;
        for (int c = 0; c < 7000; c++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk({name, "_seen"}, 64'(seen), 64'd1);
    endtask

    always @(posedge trigger[0]) begin t_rise[0] = $time; rise_q.push_back(0); rise_t.push_back($time); end
    always @(posedge trigger[1]) begin t_rise[1] = $time; rise_q.push_back(1); rise_t.push_back($time); end
    always @(negedge trigger[0]) t_fall[0] = $time;
    always @(negedge trigger[1]) t_fall[1] = $time;
    always @(posedge err[1]) t_err1 = $time;
    always @(negedge clk) if (trigger == 2'b11) overlap++;

    initial begin
        forever begin
            @(posedge trigger[0]);
            if (cfg_pre[0] > 0) echo0_drv = 1'b1;
            @(negedge trigger[0]);
            #100;
            if (cfg_pre[0] > 0) begin #(cfg_pre[0] * US); echo0_drv = 1'b0; end
            if (cfg_wid[0] > 0) begin #(cfg_dly[0] * US); echo0_drv = 1'b1; #(cfg_wid[0] * US); echo0_drv = 1'b0; end
        end
    end

    initial begin
        forever begin
            @(posedge trigger[1]);
            if (cfg_pre[1] > 0) echo1_drv = 1'b1;
            @(negedge trigger[1]);
            #100;
            if (cfg_pre[1] > 0) begin #(cfg_pre[1] * US); echo1_drv = 1'b0; end
            if (cfg_wid[1] > 0) begin #(cfg_dly[1] * US); echo1_drv = 1'b1; #(cfg_wid[1] * US); echo1_drv = 1'b0; end
        end
    end

    initial begin
        @(negedge trigger_s[0]);
        #100;
        #(20 * US) echo_s = 1'b1;
        #(1000 * US) echo_s = 1'b0;
    end

    initial begin
        vec_t vecs[3];
        int   pd1, pv1, pe1;
        vecs[0] = '{0, 20, 800,   0, 0, 0,      13, 1, 0,  511, 0, 1};
        vecs[1] = '{0, 20, 2500,  0, 50, 300,   511, 0, 1, 5, 1, 0};
        vecs[2] = '{100, 300, 600, 0, 1900, 100, 10, 1, 0, 1, 1, 0};
        pd1 = 0; pv1 = 0; pe1 = 0;

        reset = 1'b0; start = 1'b0; continuous = 1'b0; start_s = 1'b0; cont_s = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_trigger", 64'(trigger), 64'd0);
        chk("rst_distance", 64'(distance), 64'd0);
        chk("rst_valid", 64'(dist_valid), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_done_ch", 64'(done_ch), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        fork
            begin
                @(negedge clk); start_s = 1'b1; @(negedge clk); start_s = 1'b0;
                ok_s = 1'b0;
                for (int c = 0; c < 7000; c++) begin
                    @(negedge clk);
                    if (done_s) begin ok_s = 1'b1; break; end
                end
                chk("sat_done_seen", 64'(ok_s), 64'd1);
                chk("sat_distance", 64'(distance_s), 64'd15);
                chk("sat_valid", 64'(dist_valid_s), 64'd1);
                chk("sat_err", 64'(err_s), 64'd0);
                chk("sat_done_ch", 64'(done_ch_s), 64'd0);
            end
            begin
                for (int i = 0; i < 3; i++) begin
                    cfg_pre[0] = vecs[i].pre0; cfg_dly[0] = vecs[i].dly0; cfg_wid[0] = vecs[i].wid0;
                    cfg_pre[1] = vecs[i].pre1; cfg_dly[1] = vecs[i].dly1; cfg_wid[1] = vecs[i].wid1;
                    @(negedge clk); start = 1'b1; @(negedge clk); start = 1'b0;
                    wait_done($sformatf("v%0d_slot0", i), ok);
                    chk($sformatf("v%0d_done_ch0", i), 64'(done_ch), 64'd0);
                    chk($sformatf("v%0d_dist0", i), 64'(distance[8:0]), 64'(vecs[i].exp_d0));
                    chk($sformatf("v%0d_valid0", i), 64'(dist_valid[0]), 64'(vecs[i].exp_v0));
                    chk($sformatf("v%0d_err0", i), 64'(err[0]), 64'(vecs[i].exp_e0));
                    chk($sformatf("v%0d_hold_dist1", i), 64'(distance[17:9]), 64'(pd1));
                    chk($sformatf("v%0d_hold_valid1", i), 64'(dist_valid[1]), 64'(pv1));
                    chk($sformatf("v%0d_hold_err1", i), 64'(err[1]), 64'(pe1));
                    chk($sformatf("v%0d_trig_width", i), 64'((t_fall[0] - t_rise[0]) / PER), 64'(TRIG_CYC));
                    wait_done($sformatf("v%0d_slot1", i), ok);
                    chk($sformatf("v%0d_done_ch1", i), 64'(done_ch), 64'd1);
                    chk($sformatf("v%0d_dist1", i), 64'(distance[17:9]), 64'(vecs[i].exp_d1));
                    chk($sformatf("v%0d_valid1", i), 64'(dist_valid[1]), 64'(vecs[i].exp_v1));
                    chk($sformatf("v%0d_err1", i), 64'(err[1]), 64'(vecs[i].exp_e1));
                    chk($sformatf("v%0d_hold_dist0", i), 64'(distance[8:0]), 64'(vecs[i].exp_d0));
                    chk($sformatf("v%0d_slot_spacing", i), 64'((t_rise[1] - t_rise[0]) / PER), 64'(SLOT_CYC));
                    chk($sformatf("v%0d_idle_busy", i), 64'(busy), 64'd0);
                    if (i == 0) chk("v0_wait_timeout_cycles", 64'((t_err1 - t_fall[1]) / PER), 64'(TO_CYC));
                    pd1 = vecs[i].exp_d1; pv1 = vecs[i].exp_v1; pe1 = vecs[i].exp_e1;
                end
            end
        join

        cfg_pre[0] = 0; cfg_dly[0] = 20; cfg_wid[0] = 800;
        cfg_pre[1] = 0; cfg_dly[1] = 20; cfg_wid[1] = 300;
        rise_q.delete(); rise_t.delete();
        @(negedge clk); continuous = 1'b1;
        for (int s = 0; s < 4; s++) begin
            wait_done($sformatf("cont%0d", s), ok);
            chk($sformatf("cont%0d_done_ch", s), 64'(done_ch), 64'(s % 2));
            chk($sformatf("cont%0d_dist", s), 64'((s % 2 == 0) ? distance[8:0] : distance[17:9]),
                64'((s % 2 == 0) ? 13 : 5));
            if (s == 1) begin
                repeat (50) @(negedge clk);
                continuous = 1'b0;
                start = 1'b1; @(negedge clk); start = 1'b0;
            end
        end
        chk("cont_end_busy", 64'(busy), 64'd0);
        repeat (200) @(negedge clk);
        chk("cont_stays_idle", 64'(busy), 64'd0);
        chk("cont_rise_count", 64'(rise_q.size()), 64'd4);
        if (rise_q.size() == 4) begin
            for (int j = 0; j < 4; j++) chk($sformatf("cont_order%0d", j), 64'(rise_q[j]), 64'(j % 2));
            for (int j = 1; j < 4; j++)
                chk($sformatf("cont_spacing%0d", j), 64'((rise_t[j] - rise_t[j-1]) / PER), 64'(SLOT_CYC));
        end

        cfg_pre[0] = 0; cfg_dly[0] = 20; cfg_wid[0] = 800;
        cfg_wid[1] = 0;
        @(negedge clk); start = 1'b1; @(negedge clk); start = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (echo0_drv) begin ok = 1'b1; break; end
        end
        chk("rst_echo_seen", 64'(ok), 64'd1);
        repeat (200) @(negedge clk);
        #10 reset = 1'b0;
        #10;
        chk("async_rst_trigger", 64'(trigger), 64'd0);
        chk("async_rst_distance", 64'(distance), 64'd0);
        chk("async_rst_valid", 64'(dist_valid), 64'd0);
        chk("async_rst_err", 64'(err), 64'd0);
        chk("async_rst_busy", 64'(busy), 64'd0);
        repeat (2000) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b1; @(negedge clk); start = 1'b0;
        wait_done("post_rst_slot0", ok);
        chk("post_rst_done_ch", 64'(done_ch), 64'd0);
        chk("post_rst_dist0", 64'(distance[8:0]), 64'd13);
        chk("post_rst_valid0", 64'(dist_valid[0]), 64'd1);
        chk("post_rst_err0", 64'(err[0]), 64'd0);
        chk("post_rst_dist1_held", 64'(distance[17:9]), 64'd0);
        chk("trigger_onehot", 64'(overlap), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
